// File: rtl/jtag_gpio_chains_if.sv
// TAP-side and fabric-side signal bundle for the multi-chain JTAG GPIO block.
// The TAP/fabric side uses the master modport, and the scan block uses slave.
interface jtag_gpio_chains_if #(
  parameter int NR_GPIOS   = 8,
  parameter int NR_CHAINS  = 4,
  parameter int CHAIN_BITS = 2
);
  logic                          tdi;
  logic                          gpios_tdo;
  logic                          capture_dr;
  logic                          shift_dr;
  logic                          update_dr;
  logic                          scan_n_ir;
  logic                          extest_ir;
  logic [NR_CHAINS*NR_GPIOS-1:0] gpio_inputs;
  logic [NR_CHAINS*NR_GPIOS-1:0] gpio_outputs;
  logic [NR_CHAINS-1:0]          update_strobe;
  logic [CHAIN_BITS-1:0]         chain_sel;

  modport master (
    output tdi, capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir, gpio_inputs,
    input  gpios_tdo, gpio_outputs, update_strobe, chain_sel
  );

  modport slave (
    input  tdi, capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir, gpio_inputs,
    output gpios_tdo, gpio_outputs, update_strobe, chain_sel
  );
endinterface

// File: rtl/jtag_gpio_chains.sv
// Multi-bank JTAG GPIO scan register: a SCAN_N-loaded select register {mode, index}
// chooses which bank an EXTEST access captures from, shifts through and updates.
module jtag_gpio_chains #(
  parameter int                  NR_GPIOS    = 8,
  parameter int                  NR_CHAINS   = 4,
  parameter int                  CHAIN_BITS  = 2,
  parameter logic [NR_GPIOS-1:0] RESET_VALUE = '0
) (
  input logic               tck,
  input logic               reset,
  jtag_gpio_chains_if.slave bus
);
  localparam int SEL_W = CHAIN_BITS + 1;

  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W-1:0]    sel_shift_reg, sel_shift_next;
  logic [NR_GPIOS-1:0] data_shift_reg, data_shift_next;
  logic [NR_GPIOS:0]   data_cat;
  logic                bad_reg, bad_next;
  logic [NR_GPIOS-1:0] bank_reg [NR_CHAINS];
  logic [NR_CHAINS-1:0] strobe_reg;
  logic                bank_wr;

  logic [CHAIN_BITS-1:0] sel_index;
  logic                  sel_mode;
  logic                  idx_valid;
  logic [NR_GPIOS-1:0]   cap_input, cap_bank;

  assign sel_index = sel_reg[CHAIN_BITS-1:0];
  assign sel_mode  = sel_reg[SEL_W-1];
  assign idx_valid = int'(sel_index) < NR_CHAINS;

  // Explicit compare loop keeps out-of-range indices from addressing past the bank array.
  always_comb begin
    cap_input = '0;
    cap_bank  = '0;
    for (int k = 0; k < NR_CHAINS; k++) begin
      if (int'(sel_index) == k) begin
        cap_input = bus.gpio_inputs[k*NR_GPIOS +: NR_GPIOS];
        cap_bank  = bank_reg[k];
      end
    end
  end

  always_comb begin
    sel_next        = sel_reg;
    sel_shift_next  = sel_shift_reg;
    data_shift_next = data_shift_reg;
    bad_next        = bad_reg;
    bank_wr         = 1'b0;
    data_cat        = {bus.tdi, data_shift_reg};
    if (bus.scan_n_ir) begin
      if (bus.capture_dr)
        sel_shift_next = sel_reg;
      else if (bus.shift_dr)
        sel_shift_next = {bus.tdi, sel_shift_reg[SEL_W-1:1]};
      else if (bus.update_dr)
        sel_next = sel_shift_reg;
    end else if (bus.extest_ir) begin
      if (idx_valid) begin
        if (bus.capture_dr)
          data_shift_next = sel_mode ? cap_bank : cap_input;
        else if (bus.shift_dr)
          data_shift_next = data_cat[NR_GPIOS:1];
        else if (bus.update_dr)
          bank_wr = 1'b1;
      end else begin
        if (bus.capture_dr)
          bad_next = 1'b0;
        else if (bus.shift_dr)
          bad_next = bus.tdi;
      end
    end
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      sel_reg        <= '0;
      sel_shift_reg  <= '0;
      data_shift_reg <= '0;
      bad_reg        <= 1'b0;
      strobe_reg     <= '0;
      for (int k = 0; k < NR_CHAINS; k++)
        bank_reg[k] <= RESET_VALUE;
    end else begin
      sel_reg        <= sel_next;
      sel_shift_reg  <= sel_shift_next;
      data_shift_reg <= data_shift_next;
      bad_reg        <= bad_next;
      for (int k = 0; k < NR_CHAINS; k++) begin
        if (bank_wr && int'(sel_index) == k)
          bank_reg[k] <= data_shift_reg;
        strobe_reg[k] <= bank_wr && (int'(sel_index) == k);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NR_CHAINS; gi++) begin : g_bank_out
      assign bus.gpio_outputs[gi*NR_GPIOS +: NR_GPIOS] = bank_reg[gi];
    end
  endgenerate

  // Invalid index routes the single scratch flop instead of the data shift register.
  assign bus.gpios_tdo = bus.scan_n_ir ? sel_shift_reg[0] :
                         bus.extest_ir ? (idx_valid ? data_shift_reg[0] : bad_reg) :
                         1'b0;
  assign bus.update_strobe = strobe_reg;
  assign bus.chain_sel     = sel_index;
endmodule
